// File: rtl/elink_uplink_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : elink_uplink_rx_pkg
// Purpose : Shared types and constants for the e-link uplink receiver.
// Rev     : 1.0  initial release
// ============================================================================
package elink_uplink_rx_pkg;

    localparam int          UPLINK_W  = 76;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
`ifdef ELINK_RX_CRC_EN
        ,
        CHECK   = 2'd3
`endif
    } asm_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_DATA = 2'd1,
        RD_DONE = 2'd2
    } rd_state_t;

`ifdef ELINK_RX_CRC_EN
    // One byte of a non-reflected CRC-8, MSB first.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/elink_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module  : elink_frame_fifo
// Purpose : Whole-frame FIFO; a pop in the same cycle frees room for a push.
// Rev     : 1.0  initial release
// ============================================================================
module elink_frame_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 76
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_occ_w'(DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_occ_w'(1);
                2'b01:   r_count <= r_count - c_occ_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/elink_uplink_rx.sv
`default_nettype none
// ============================================================================
// Module  : elink_uplink_rx
// Purpose : E-link byte stream to 76-bit frame assembler, FIFO and core reader.
//           Define ELINK_RX_CRC_EN to require a trailing CRC-8 byte per frame.
// Rev     : 1.0  initial release
// ============================================================================
module elink_uplink_rx
    import elink_uplink_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int FRAME_BYTES = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    input  logic                rx_sop,
    input  logic                start_read_elink,
    output logic [UPLINK_W-1:0] data_tra_uplink,
    output logic                irq_elink,
    output logic                end_read_elink,
    output logic                frame_err,
    output logic [7:0]          drop_cnt
);

    localparam int c_cnt_w = $clog2(FRAME_BYTES + 1);
    localparam int c_occ_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_BYTES - 1);
`ifdef ELINK_RX_CRC_EN
    localparam asm_state_t c_after_collect = CHECK;
`else
    localparam asm_state_t c_after_collect = COMMIT;
`endif

    asm_state_t             r_asm_state;
    rd_state_t              r_rd_state;
    logic [79:0]            r_shift;
    logic [c_cnt_w-1:0]     r_byte_cnt;
    logic                   r_frame_err;
    logic [7:0]             r_drop_cnt;
    logic [UPLINK_W-1:0]    r_data;
    logic                   r_end_read;
    logic                   r_irq;
`ifdef ELINK_RX_CRC_EN
    logic [7:0]             r_crc;
    logic                   w_crc_bad;
`endif

    logic [79:0]            w_shift_next;
    logic                   w_sop;
    logic                   w_abort;
    logic                   w_commit;
    logic                   w_commit_drop;
    logic                   w_drop;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [UPLINK_W-1:0]    w_head;
    logic [c_occ_w-1:0]     w_count;
    logic [c_occ_w-1:0]     w_occ_next;
    logic [7:0]             w_unused_msbs;

    assign w_shift_next  = {r_shift[71:0], rx_byte};
    assign w_unused_msbs = r_shift[79:72];
    assign w_sop         = rx_valid & rx_sop;
    assign w_commit      = (r_asm_state == COMMIT);
    assign w_pop         = (r_rd_state == RD_DONE);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push        = w_commit & (~w_full | w_pop);
    assign w_commit_drop = w_commit & ~w_push;

`ifdef ELINK_RX_CRC_EN
    assign w_abort   = w_sop & ((r_asm_state == COLLECT) | (r_asm_state == CHECK));
    assign w_crc_bad = (r_asm_state == CHECK) & rx_valid & ~rx_sop & (rx_byte != r_crc);
    assign w_drop    = w_abort | w_commit_drop | w_crc_bad;
`else
    assign w_abort   = w_sop & (r_asm_state == COLLECT);
    assign w_drop    = w_abort | w_commit_drop;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_asm_state <= IDLE;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_drop_cnt  <= '0;
`ifdef ELINK_RX_CRC_EN
            r_crc       <= '0;
`endif
        end else begin
            r_frame_err <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_asm_state)
                IDLE: begin
                    if (w_sop) begin
                        r_shift     <= w_shift_next;
                        r_byte_cnt  <= c_cnt_one;
`ifdef ELINK_RX_CRC_EN
                        r_crc       <= crc8_update(8'h00, rx_byte);
`endif
                        r_asm_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        r_shift <= w_shift_next;
                        if (rx_sop) begin
                            r_byte_cnt <= c_cnt_one;
`ifdef ELINK_RX_CRC_EN
                            r_crc      <= crc8_update(8'h00, rx_byte);
`endif
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_cnt_one;
`ifdef ELINK_RX_CRC_EN
                            r_crc      <= crc8_update(r_crc, rx_byte);
`endif
                            if (r_byte_cnt == c_cnt_last) begin
                                r_asm_state <= c_after_collect;
                            end
                        end
                    end
                end
`ifdef ELINK_RX_CRC_EN
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_sop) begin
                            r_shift     <= w_shift_next;
                            r_byte_cnt  <= c_cnt_one;
                            r_crc       <= crc8_update(8'h00, rx_byte);
                            r_asm_state <= COLLECT;
                        end else if (rx_byte == r_crc) begin
                            r_asm_state <= COMMIT;
                        end else begin
                            r_asm_state <= IDLE;
                        end
                    end
                end
`endif
                COMMIT:  r_asm_state <= IDLE;
                default: r_asm_state <= IDLE;
            endcase
        end
    end

    // end_read_elink is high exactly while the reader sits in RD_DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= RD_IDLE;
            r_data     <= '0;
            r_end_read <= 1'b0;
        end else begin
            r_end_read <= 1'b0;
            case (r_rd_state)
                RD_IDLE: begin
                    if (start_read_elink && !w_empty) begin
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    r_data     <= w_head;
                    r_end_read <= 1'b1;
                    r_rd_state <= RD_DONE;
                end
                RD_DONE: r_rd_state <= RD_IDLE;
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign w_occ_next = w_count + c_occ_w'(w_push) - c_occ_w'(w_pop & ~w_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_occ_next != '0);
        end
    end

    elink_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UPLINK_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_shift[UPLINK_W-1:0]),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign data_tra_uplink = r_data;
    assign irq_elink       = r_irq;
    assign end_read_elink  = r_end_read;
    assign frame_err       = r_frame_err;
    assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/elink_uplink_rx.md
ELINK_UPLINK_RX -- requirements
Module: elink_uplink_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of complete 76-bit frames buffered (power of two, 2..8).
REQ-002 SHALL have parameter FRAME_BYTES, default 10, payload bytes per frame (80 bits; bits 79:76 discarded).
REQ-003 clk  in  1  single system clock, all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 rx_byte  in  8  e-link deserialised byte, MSB-first within the frame.
REQ-006 rx_valid  in  1  rx_byte valid this cycle.
REQ-007 rx_sop  in  1  rx_byte is the first byte of a frame (qualified by rx_valid).
REQ-008 start_read_elink  in  1  core request to read the head frame (1-cycle pulse).
REQ-009 data_tra_uplink  out  76  head frame payload to core.
REQ-010 irq_elink  out  1  high while at least one complete frame is buffered.
REQ-011 end_read_elink  out  1  1-cycle pulse: data_tra_uplink valid, frame consumed.
REQ-012 frame_err  out  1  1-cycle pulse on any dropped or truncated frame.
REQ-013 drop_cnt  out  8  saturating count of dropped frames.

Function
REQ-014 Assembler FSM SHALL use states IDLE, COLLECT, COMMIT; IDLE->COLLECT on rx_valid&rx_sop, COLLECT->COMMIT on the FRAME_BYTES-th byte, COMMIT->IDLE next cycle.
REQ-015 Bytes SHALL shift into an 80-bit register MSB-first; payload = bits 75:0.
REQ-016 rx_valid without rx_sop in IDLE SHALL be ignored with no error.
REQ-017 rx_sop in COLLECT SHALL abort the partial frame, pulse frame_err, increment drop_cnt, and restart collection with that byte.
REQ-018 COMMIT SHALL write the frame to the FIFO if not full; if full, the new frame is dropped (oldest kept), frame_err pulses, drop_cnt increments.
REQ-019 drop_cnt SHALL saturate at 255.
REQ-020 Reader FSM SHALL use states RD_IDLE, RD_DATA, RD_DONE; RD_IDLE->RD_DATA on start_read_elink while non-empty; RD_DATA->RD_DONE next cycle; RD_DONE->RD_IDLE next cycle.
REQ-021 data_tra_uplink SHALL be registered from FIFO head in RD_DATA and held stable until the next read; end_read_elink SHALL be high exactly in RD_DONE (latency 2 cycles from start_read_elink), FIFO popped same cycle.
REQ-022 start_read_elink while empty or while reader not in RD_IDLE SHALL be ignored.
REQ-023 Simultaneous COMMIT write and RD_DONE pop SHALL both succeed, including when full (pop frees the slot first).
REQ-024 irq_elink SHALL be registered, equal to (occupancy>0) after the cycle's push/pop, and drop in the cycle after the last pop.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 On rst low, asynchronously: both FSMs idle, FIFO empty, data_tra_uplink=0, irq_elink=0, end_read_elink=0, frame_err=0, drop_cnt=0.
REQ-027 Reset mid-frame or mid-read SHALL discard all partial and buffered frames without error pulses after release.

Configuration
REQ-028 Macro ELINK_RX_CRC_EN SHALL, when defined, expect one extra CRC-8 byte (poly 0x07, init 0x00, over the FRAME_BYTES payload bytes); COLLECT->CHECK->COMMIT; mismatch drops frame, pulses frame_err, increments drop_cnt.
REQ-029 Without ELINK_RX_CRC_EN frames SHALL be exactly FRAME_BYTES bytes, no CHECK state, no CRC logic.

Structure
REQ-030 Shared package SHALL hold assembler/reader state enums, UPLINK_W=76, CRC8_POLY=8'h07.
REQ-031 FIFO storage SHALL be sub-module elink_frame_fifo (push, pop, full, empty, count).

Verification
REQ-032 One frame bytes 00..09 -> irq_elink rises; start_read_elink pulse -> end_read_elink 2 cycles later, data_tra_uplink=76'h0_0102_0304_0506_0708_09 (top nibble of byte 00 dropped).
REQ-033 Three back-to-back frames with no reads, depth 2 -> third dropped, frame_err 1 pulse, drop_cnt=1, reads return frames 1 then 2.
REQ-034 rx_sop at byte 5 -> frame_err pulse, drop_cnt=1, following complete frame delivered intact.
REQ-035 Full FIFO, frame commit coinciding with RD_DONE -> no drop, occupancy stays 2.
REQ-036 rst low during byte 4 and again during RD_DATA -> all outputs 0, irq_elink=0, no end_read_elink.
REQ-037 With ELINK_RX_CRC_EN, bad CRC byte -> frame dropped, drop_cnt=1; correct CRC -> frame delivered.
